// File: rtl/led_pkg.sv
// led_pkg: shared command codes, FSM states and timing defaults for the LED SPI front end
package led_pkg;

    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_ADDR_WR = 8'h2B;
    localparam logic [7:0] CMD_DATA_WR = 8'h2C;
    localparam logic [7:0] CMD_REFRESH = 8'h2D;

    localparam logic [7:0] T0H_DEF = 8'd8;
    localparam logic [7:0] T0S_DEF = 8'd17;
    localparam logic [7:0] T1H_DEF = 8'd16;
    localparam logic [7:0] T1S_DEF = 8'd9;

    localparam int PIXEL_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_ADDR,
        ST_DATA,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: byte-receiver input, pixel RAM write port and LED stage controls
interface spi_cmd_decoder_if
    import led_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic               spi_cs_n_in;
    logic               byte_rdy_in;
    logic [7:0]         byte_data_in;
    logic               ram_wr_en_out;
    logic [ADDR_W-1:0]  ram_wr_addr_out;
    logic [PIXEL_W-1:0] ram_wr_data_out;
    logic [7:0]         t0h_time_out;
    logic [7:0]         t0s_time_out;
    logic [7:0]         t1h_time_out;
    logic [7:0]         t1s_time_out;
    logic               refresh_out;

    modport slave (
        input  spi_cs_n_in, byte_rdy_in, byte_data_in,
        output ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
        output t0h_time_out, t0s_time_out, t1h_time_out, t1s_time_out, refresh_out
    );

    modport master (
        output spi_cs_n_in, byte_rdy_in, byte_data_in,
        input  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
        input  t0h_time_out, t0s_time_out, t1h_time_out, t1s_time_out, refresh_out
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit with selectable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;

    // Two flops in series give metastability time before the bit is used
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: frames SPI bytes by chip select and decodes config, address, pixel and refresh commands
module spi_cmd_decoder
    import led_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spi_cmd_decoder_if.slave  bus
);
    logic               cs_n_s, cs_prev_q, frame_end, byte_ok;
    logic [7:0]         d;
    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [7:0]         b0_q, b0_d, b1_q, b1_d, hi_q, hi_d;
    logic [ADDR_W-1:0]  base_q, base_d, ptr_q, ptr_d;
    logic [7:0]         t0h_q, t0h_d, t0s_q, t0s_d, t1h_q, t1h_d, t1s_q, t1s_d;
    logic               wr_en_q, wr_en_d, refresh_q, refresh_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_W-1:0] wr_data_q, wr_data_d;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   (bus.spi_cs_n_in),
        .q_o   (cs_n_s)
    );

    assign d         = bus.byte_data_in;
    assign frame_end = cs_n_s & ~cs_prev_q;
    assign byte_ok   = bus.byte_rdy_in & ~cs_n_s;

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and datapath updates; frame end overrides any byte in the same cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        hi_d      = hi_q;
        base_d    = base_q;
        ptr_d     = ptr_q;
        t0h_d     = t0h_q;
        t0s_d     = t0s_q;
        t1h_d     = t1h_q;
        t1s_d     = t1s_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        refresh_d = 1'b0;
        if (frame_end) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (byte_ok) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d     = '0;
                    state_d   = d == CMD_CONF_WR ? ST_CONF :
                                d == CMD_ADDR_WR ? ST_ADDR :
                                d == CMD_DATA_WR ? ST_DATA : ST_DISCARD;
                    ptr_d     = d == CMD_DATA_WR ? base_q : ptr_q;
                    refresh_d = d == CMD_REFRESH;
                end
                ST_CONF: begin
                    t0h_d   = cnt_q == 2'd0 ? d : t0h_q;
                    t0s_d   = cnt_q == 2'd1 ? d : t0s_q;
                    t1h_d   = cnt_q == 2'd2 ? d : t1h_q;
                    t1s_d   = cnt_q == 2'd3 ? d : t1s_q;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = cnt_q == 2'd3 ? ST_DISCARD : ST_CONF;
                end
                ST_ADDR: begin
                    hi_d    = cnt_q == 2'd0 ? d : hi_q;
                    base_d  = cnt_q == 2'd0 ? base_q : ADDR_W'({hi_q, d});
                    cnt_d   = 2'd1;
                    state_d = cnt_q == 2'd0 ? ST_ADDR : ST_DISCARD;
                end
                ST_DATA: begin
                    b0_d = cnt_q == 2'd0 ? d : b0_q;
                    b1_d = cnt_q == 2'd1 ? d : b1_q;
                    if (cnt_q == 2'd2) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = {b0_q, b1_q, d};
                        ptr_d     = ptr_q + ADDR_W'(1);
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cs_prev_q <= 1'b1;
            cnt_q     <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            hi_q      <= '0;
            base_q    <= '0;
            ptr_q     <= '0;
            t0h_q     <= T0H_DEF;
            t0s_q     <= T0S_DEF;
            t1h_q     <= T1H_DEF;
            t1s_q     <= T1S_DEF;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            refresh_q <= 1'b0;
        end else begin
            cs_prev_q <= cs_n_s;
            cnt_q     <= cnt_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            hi_q      <= hi_d;
            base_q    <= base_d;
            ptr_q     <= ptr_d;
            t0h_q     <= t0h_d;
            t0s_q     <= t0s_d;
            t1h_q     <= t1h_d;
            t1s_q     <= t1s_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            refresh_q <= refresh_d;
        end
    end

    assign bus.ram_wr_en_out   = wr_en_q;
    assign bus.ram_wr_addr_out = wr_addr_q;
    assign bus.ram_wr_data_out = wr_data_q;
    assign bus.t0h_time_out    = t0h_q;
    assign bus.t0s_time_out    = t0s_q;
    assign bus.t1h_time_out    = t1h_q;
    assign bus.t1s_time_out    = t1s_q;
    assign bus.refresh_out     = refresh_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: table vectors, corner sequences and random frames against a frame-level model
module tb_spi_cmd_decoder;
    import led_pkg::*;

    localparam int ADDR_W = 8;

    typedef struct {
        logic [63:0]      bytes;
        int               n;
        logic [31:0]      tim;
        int               nwr;
        logic [1:0][31:0] w;
        int               nref;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus();

    spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          ref_cnt = 0;
    int          exp_ref = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  frm[$];
    logic [7:0]  m_t[4];
    logic [ADDR_W-1:0] m_base;
    logic [31:0] m_last;
    vec_t        tbl[10];

    // Observe every write and refresh pulse, away from the active edge
    always @(negedge clk) begin
        if (bus.ram_wr_en_out) got_q.push_back(32'({bus.ram_wr_addr_out, bus.ram_wr_data_out}));
        if (bus.refresh_out) ref_cnt++;
    end

    function automatic logic [31:0] tim_out();
        return {bus.t0h_time_out, bus.t0s_time_out, bus.t1h_time_out, bus.t1s_time_out};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.byte_rdy_in  = 1'b1;
        bus.byte_data_in = b;
        @(posedge clk);
        #1;
        bus.byte_rdy_in  = 1'b0;
    endtask

    task automatic model_reset();
        m_t    = '{T0H_DEF, T0S_DEF, T1H_DEF, T1S_DEF};
        m_base = '0;
        m_last = '0;
    endtask

    // Effect of one whole frame, computed from the command rules
    task automatic model_frame();
        int n;
        n = frm.size();
        if (n == 0) return;
        if (frm[0] == 8'h2A) begin
            for (int i = 1; i < n && i <= 4; i++) m_t[i-1] = frm[i];
        end else if (frm[0] == 8'h2B) begin
            if (n >= 3) m_base = ADDR_W'({frm[1], frm[2]} % (1 << ADDR_W));
        end else if (frm[0] == 8'h2C) begin
            for (int k = 0; 3 * k + 3 < n; k++) begin
                m_last = {8'((int'(m_base) + k) % (1 << ADDR_W)), frm[3*k+1], frm[3*k+2], frm[3*k+3]};
                exp_q.push_back(m_last);
            end
        end else if (frm[0] == 8'h2D) begin
            exp_ref++;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        frm.delete();
        ref_cnt = 0;
        exp_ref = 0;
    endtask

    task automatic end_frame();
        bus.spi_cs_n_in = 1'b1;
        idle(3);
        put_byte(8'($urandom));
        idle(3);
        model_frame();
    endtask

    task automatic send_frame();
        bus.spi_cs_n_in = 1'b0;
        idle(3 + int'($urandom_range(0, 2)));
        foreach (frm[i]) begin
            put_byte(frm[i]);
            idle(int'($urandom_range(0, 1)));
        end
        end_frame();
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_refresh"}, 64'(ref_cnt), 64'(exp_ref));
        chk({tag, "_timing"}, 64'(tim_out()), 64'({m_t[0], m_t[1], m_t[2], m_t[3]}));
        chk({tag, "_wr_hold"}, 64'({bus.ram_wr_addr_out, bus.ram_wr_data_out}), 64'(m_last));
        clear_obs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'h2A0A14120CFF0000, 6, 32'h0A14120C, 0, 64'h0, 0};
        tbl[1] = '{64'h2B00050000000000, 3, 32'h0A14120C, 0, 64'h0, 0};
        tbl[2] = '{64'h2C11223344556600, 7, 32'h0A14120C, 2, {32'h06445566, 32'h05112233}, 0};
        tbl[3] = '{64'h2C11223300000000, 4, 32'h0A14120C, 1, {32'h0, 32'h05112233}, 0};
        tbl[4] = '{64'h2B00FF0000000000, 3, 32'h0A14120C, 0, 64'h0, 0};
        tbl[5] = '{64'h2C01020304050600, 7, 32'h0A14120C, 2, {32'h00040506, 32'hFF010203}, 0};
        tbl[6] = '{64'h2CAABB0000000000, 3, 32'h0A14120C, 0, 64'h0, 0};
        tbl[7] = '{64'h2CCCDDEE00000000, 4, 32'h0A14120C, 1, {32'h0, 32'hFFCCDDEE}, 0};
        tbl[8] = '{64'h2D00000000000000, 1, 32'h0A14120C, 0, 64'h0, 1};
        tbl[9] = '{64'h7F2A010203040000, 6, 32'h0A14120C, 0, 64'h0, 0};

        bus.spi_cs_n_in  = 1'b1;
        bus.byte_rdy_in  = 1'b0;
        bus.byte_data_in = 8'h00;
        model_reset();
        idle(3);
        chk("rst_wr", 64'({bus.ram_wr_en_out, bus.ram_wr_addr_out, bus.ram_wr_data_out}), 64'h0);
        chk("rst_timing", 64'(tim_out()), 64'h08111009);
        chk("rst_refresh", 64'(bus.refresh_out), 64'h0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            frm.delete();
            for (int j = 0; j < tbl[i].n; j++) frm.push_back(tbl[i].bytes[63-8*j -: 8]);
            send_frame();
            chk("tbl_timing", 64'(tim_out()), 64'(tbl[i].tim));
            chk("tbl_wr_count", 64'(got_q.size()), 64'(tbl[i].nwr));
            for (int j = 0; j < tbl[i].nwr && j < got_q.size(); j++) chk("tbl_wr", 64'(got_q[j]), 64'(tbl[i].w[j]));
            chk("tbl_refresh", 64'(ref_cnt), 64'(tbl[i].nref));
            clear_obs();
        end

        frm = '{8'h2D};
        bus.spi_cs_n_in = 1'b0;
        idle(3);
        put_byte(8'h2D);
        @(negedge clk);
        chk("refresh_pulse", 64'(bus.refresh_out), 64'h1);
        @(negedge clk);
        chk("refresh_width", 64'(bus.refresh_out), 64'h0);
        @(posedge clk);
        #1;
        end_frame();
        cmp_model("refresh_seq");

        frm = '{8'h2C, 8'hAA, 8'hBB};
        bus.spi_cs_n_in = 1'b0;
        idle(3);
        foreach (frm[i]) put_byte(frm[i]);
        bus.spi_cs_n_in = 1'b1;
        idle(2);
        put_byte(8'hCC);
        idle(4);
        model_frame();
        cmp_model("drop_at_end");
        frm = '{8'h2C, 8'hCC, 8'hDD, 8'hEE};
        send_frame();
        cmp_model("after_partial");

        for (int f = 0; f < 30; f++) begin
            int r;
            int len;
            frm.delete();
            r = int'($urandom_range(0, 4));
            frm.push_back(r == 0 ? 8'h2A : r == 1 ? 8'h2B : r == 2 ? 8'h2C : r == 3 ? 8'h2D : 8'($urandom));
            len = int'($urandom_range(0, 10));
            for (int j = 0; j < len; j++) frm.push_back(8'($urandom));
            send_frame();
            cmp_model("rand");
        end

        bus.spi_cs_n_in = 1'b0;
        idle(3);
        put_byte(8'h2C);
        put_byte(8'h11);
        put_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_wr", 64'({bus.ram_wr_en_out, bus.ram_wr_addr_out, bus.ram_wr_data_out}), 64'h0);
        chk("midrst_timing", 64'(tim_out()), 64'h08111009);
        chk("midrst_refresh", 64'(bus.refresh_out), 64'h0);
        chk("midrst_no_write", 64'(got_q.size()), 64'h0);
        model_reset();
        clear_obs();
        idle(3);
        frm = '{8'h2A, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (frm[i]) put_byte(frm[i]);
        end_frame();
        cmp_model("post_rst_conf");
        frm = '{8'h2C, 8'h12, 8'h34, 8'h56};
        send_frame();
        cmp_model("post_rst_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
